// File: rtl/alu_cu_pkg.sv
// rtl/alu_cu_pkg.sv - shared opcodes, FSM states and instruction fields for the ALU control unit
// Purpose: single source of truth for the instruction format and the opcode set.
// Contents: opcode localparams, FSM state enum, field bit positions, is_legal_op().
package alu_cu_pkg;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [5:0] OP_NE  = 6'b100001;
  localparam logic [5:0] OP_LE  = 6'b100010;
  localparam logic [5:0] OP_GT  = 6'b100011;
  localparam logic [5:0] OP_SHL = 6'b110000;
  localparam logic [5:0] OP_SHR = 6'b110001;
  localparam logic [5:0] OP_SRA = 6'b110010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } cu_state_e;

  localparam int OP_LSB      = 26;
  localparam int RD_LSB      = 23;
  localparam int RS1_LSB     = 20;
  localparam int RS2_LSB     = 17;
  localparam int IMM_SEL_BIT = 16;
  localparam int IMM_LSB     = 0;

  // NOP counts as legal: it retires with a done pulse, it just writes nothing.
  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT,
      OP_SHL, OP_SHR, OP_SRA: is_legal_op = 1'b1;
      default:                is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_control_unit_regfile.sv
// rtl/alu_control_unit_regfile.sv - NUM_REGS x DATA_W register file with r0 hardwired to zero
// Purpose: operand storage for the ALU control unit (module cu_regfile).
// Ports: clk, rst (sync, active-high, clears all entries); we/waddr/wdata synchronous write;
//        raddr1/rdata1, raddr2/rdata2 and dbg_addr/dbg_data combinational reads.
module cu_regfile #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Reads see the pre-write contents during the write cycle (no bypass).
  assign rdata1   = (raddr1   == '0) ? '0 : mem_q[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : mem_q[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_control_unit.sv
// rtl/alu_control_unit.sv - multi-cycle decode/execute/writeback controller in front of a 32-bit ALU
// Purpose: accepts instructions over valid/ready, drives the ALU, writes results back, keeps C/Z/N.
// Ports: clk, rst (sync, active-high); instr_valid/instr_ready/instr; alu_a/alu_b/alu_opcode out;
//        alu_ans1/alu_ans2/alu_z/alu_n in; done/illegal pulses; flag_c/flag_z/flag_n;
//        dbg_addr/dbg_data debug read.
// Build option: ALU_CU_PERF_CNT_EN adds retired_cnt/illegal_cnt wrapping event counters.
module alu_control_unit
  import alu_cu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_ans1,
  input  logic              alu_ans2,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic              done,
  output logic              illegal,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_n,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_CU_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       illegal_cnt
`endif
);

  cu_state_e         state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [5:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              res_c_q, res_c_d, res_z_q, res_z_d, res_n_q, res_n_d;
  logic              flag_c_q, flag_c_d, flag_z_q, flag_z_d, flag_n_q, flag_n_d;
  logic              done_q, done_d, illegal_q, illegal_d;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, imm_ext;

  logic [5:0]    f_op;
  logic [AW-1:0] f_rd, f_rs1, f_rs2;
  logic          f_imm_sel;

  assign f_op      = instr_q[OP_LSB +: 6];
  assign f_rd      = instr_q[RD_LSB +: AW];
  assign f_rs1     = instr_q[RS1_LSB +: AW];
  assign f_rs2     = instr_q[RS2_LSB +: AW];
  assign f_imm_sel = instr_q[IMM_SEL_BIT];
  assign imm_ext   = {{(DATA_W-16){1'b0}}, instr_q[IMM_LSB +: 16]};

  cu_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (f_rd),
    .wdata    (res_q),
    .raddr1   (f_rs1),
    .rdata1   (rf_rdata1),
    .raddr2   (f_rs2),
    .rdata2   (rf_rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    res_d     = res_q;
    res_c_d   = res_c_q;
    res_z_d   = res_z_q;
    res_n_d   = res_n_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // An illegal op leaves the ALU operand registers untouched.
        if (!is_legal_op(f_op)) begin
          illegal_d = 1'b1;
          state_d   = IDLE;
        end else begin
          alu_a_d  = rf_rdata1;
          alu_b_d  = f_imm_sel ? imm_ext : rf_rdata2;
          alu_op_d = f_op;
          state_d  = (f_op == OP_NOP) ? WB : EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_ans1;
        res_c_d = alu_ans2;
        res_z_d = alu_z;
        res_n_d = alu_n;
        state_d = WB;
      end
      WB: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (alu_op_q != OP_NOP) begin
          rf_we    = 1'b1;
          flag_z_d = res_z_q;
          flag_n_d = res_n_q;
          if ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) flag_c_d = res_c_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= OP_NOP;
      res_q     <= '0;
      res_c_q   <= 1'b0;
      res_z_q   <= 1'b0;
      res_n_q   <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      res_q     <= res_d;
      res_c_q   <= res_c_d;
      res_z_q   <= res_z_d;
      res_n_q   <= res_n_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef ALU_CU_PERF_CNT_EN
  logic [31:0] retired_cnt_q, illegal_cnt_q;

  // Counted alongside the pulse registers so each count moves with its pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (done_d)    retired_cnt_q <= retired_cnt_q + 32'd1;
      if (illegal_d) illegal_cnt_q <= illegal_cnt_q + 32'd1;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

  assign instr_ready = (state_q == IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_op_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign flag_c      = flag_c_q;
  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// tb/tb_alu_control_unit.sv - self-checking bench for alu_control_unit with a behavioural ALU and model
module tb_alu_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'h0;
  logic [31:0] alu_a, alu_b, alu_ans1, dbg_data;
  logic [5:0]  alu_opcode;
  logic        alu_ans2, alu_z, alu_n;
  logic        done, illegal, flag_c, flag_z, flag_n;
  logic [2:0]  dbg_addr = 3'd0;
`ifdef ALU_CU_PERF_CNT_EN
  logic [31:0] retired_cnt, illegal_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] m_reg [8];
  logic        m_c, m_z, m_n;
  int          cnt_done, cnt_ill;

  always #5 clk = ~clk;

  alu_control_unit dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_ans1(alu_ans1), .alu_ans2(alu_ans2), .alu_z(alu_z), .alu_n(alu_n),
    .done(done), .illegal(illegal),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_CU_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  // Behavioural ALU: {carry/borrow, result}. Non-arithmetic ops return a junk carry bit.
  function automatic logic [32:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    r = {a[0] ^ b[0], 32'h0};
    case (op)
      6'h10: r = {1'b0, a} + {1'b0, b};
      6'h11: r = {(a < b), a - b};
      6'h20: r[31:0] = {31'h0, a == b};
      6'h21: r[31:0] = {31'h0, a != b};
      6'h22: r[31:0] = {31'h0, $signed(a) <= $signed(b)};
      6'h23: r[31:0] = {31'h0, $signed(a) >  $signed(b)};
      6'h30: r[31:0] = a << b[4:0];
      6'h31: r[31:0] = a >> b[4:0];
      6'h32: r[31:0] = $signed(a) >>> b[4:0];
      default: r[31:0] = 32'h0;
    endcase
    return r;
  endfunction

  assign {alu_ans2, alu_ans1} = ref_alu(alu_opcode, alu_a, alu_b);
  assign alu_z = (alu_ans1 == 32'h0);
  assign alu_n = alu_ans1[31];

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                      input logic [2:0] rs2, input logic isel, input logic [15:0] imm);
    return {op, rd, rs1, rs2, isel, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
    cnt_done = 0; cnt_ill = 0;
  endtask

  task automatic run_instr(input logic [31:0] ins);
    logic [5:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [31:0] a, b, res;
    logic [32:0] r;
    logic        legal;
    op  = ins[31:26];
    rd  = ins[25:23];
    rs1 = ins[22:20];
    rs2 = ins[19:17];
    a   = m_reg[rs1];
    b   = ins[16] ? {16'h0, ins[15:0]} : m_reg[rs2];
    legal = op inside {6'h00, 6'h10, 6'h11, 6'h20, 6'h21, 6'h22, 6'h23, 6'h30, 6'h31, 6'h32};
    @(negedge clk);
    check("ready_idle", {31'h0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom;
    check("ready_decode", {31'h0, instr_ready}, 32'd0);
    check("done_decode", {31'h0, done}, 32'd0);
    if (!legal) begin
      @(negedge clk);
      check("illegal_pulse", {31'h0, illegal}, 32'd1);
      check("done_illegal", {31'h0, done}, 32'd0);
      check("ready_after_illegal", {31'h0, instr_ready}, 32'd1);
      check("flags_illegal", {29'h0, flag_c, flag_z, flag_n}, {29'h0, m_c, m_z, m_n});
      cnt_ill++;
    end else if (op == 6'h00) begin
      @(negedge clk);
      check("done_nop_wb", {31'h0, done}, 32'd0);
      @(negedge clk);
      check("done_nop", {31'h0, done}, 32'd1);
      check("flags_nop", {29'h0, flag_c, flag_z, flag_n}, {29'h0, m_c, m_z, m_n});
      cnt_done++;
    end else begin
      @(negedge clk);
      check("alu_a_exec", alu_a, a);
      check("alu_b_exec", alu_b, b);
      check("alu_op_exec", {26'h0, alu_opcode}, {26'h0, op});
      check("ready_exec", {31'h0, instr_ready}, 32'd0);
      r   = ref_alu(op, a, b);
      res = r[31:0];
      @(negedge clk);
      dbg_addr = rd;
      #1;
      check("dbg_old_in_wb", dbg_data, m_reg[rd]);
      check("done_wb", {31'h0, done}, 32'd0);
      @(negedge clk);
      if (rd != 3'd0) m_reg[rd] = res;
      m_z = (res == 32'h0);
      m_n = res[31];
      if (op == 6'h10 || op == 6'h11) m_c = r[32];
      cnt_done++;
      check("done_pulse", {31'h0, done}, 32'd1);
      check("illegal_quiet", {31'h0, illegal}, 32'd0);
      check("dbg_new", dbg_data, m_reg[rd]);
      check("flags", {29'h0, flag_c, flag_z, flag_n}, {29'h0, m_c, m_z, m_n});
    end
    @(negedge clk);
    check("done_one_cycle", {31'h0, done}, 32'd0);
    check("illegal_one_cycle", {31'h0, illegal}, 32'd0);
  endtask

  logic [5:0] legal_ops [10];
  logic [5:0] bad_ops [4];

  initial begin
    legal_ops = '{6'h00, 6'h10, 6'h11, 6'h20, 6'h21, 6'h22, 6'h23, 6'h30, 6'h31, 6'h32};
    bad_ops   = '{6'h01, 6'h12, 6'h24, 6'h3f};
    model_reset();

    // Reset for two cycles, then check reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'h0, instr_ready}, 32'd1);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_illegal", {31'h0, illegal}, 32'd0);
    check("rst_flags", {29'h0, flag_c, flag_z, flag_n}, 32'd0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_alu_op", {26'h0, alu_opcode}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("rst_dbg", dbg_data, 32'h0);
    end

    // Directed sequence.
    run_instr(32'h40910011);
    check("r1_add", m_reg[1], 32'h00000011);
    run_instr(enc(6'h11, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0012));
    check("sub_c", {31'h0, flag_c}, 32'd1);
    check("sub_n", {31'h0, flag_n}, 32'd1);
    dbg_addr = 3'd2; #1;
    check("r2_sub", dbg_data, 32'hFFFFFFFF);
    run_instr(enc(6'h30, 3'd3, 3'd1, 3'd0, 1'b1, 16'h0004));
    run_instr(enc(6'h20, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0000));
    dbg_addr = 3'd3; #1;
    check("r3_shl", dbg_data, 32'h00000110);
    dbg_addr = 3'd4; #1;
    check("r4_eq", dbg_data, 32'h00000001);
    check("c_kept", {31'h0, flag_c}, 32'd1);
    run_instr(enc(6'h3f, 3'd6, 3'd1, 3'd2, 1'b0, 16'h1234));
    run_instr(enc(6'h10, 3'd0, 3'd1, 3'd0, 1'b1, 16'h0005));
    dbg_addr = 3'd0; #1;
    check("r0_zero", dbg_data, 32'h0);
    run_instr(enc(6'h00, 3'd5, 3'd1, 3'd1, 1'b0, 16'h0000));

    // Valid held while busy, then reset during EXEC of ADD r5.
    @(negedge clk);
    instr_valid = 1'b1;
    instr = enc(6'h10, 3'd5, 3'd1, 3'd0, 1'b1, 16'h0007);
    @(negedge clk);
    check("busy_ready_decode", {31'h0, instr_ready}, 32'd0);
    instr = $urandom;
    @(negedge clk);
    check("busy_ready_exec", {31'h0, instr_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;
    model_reset();
    dbg_addr = 3'd5; #1;
    check("rst_r5", dbg_data, 32'h0);
    check("rst_mid_ready", {31'h0, instr_ready}, 32'd1);
    check("rst_mid_done", {31'h0, done}, 32'd0);
    check("rst_mid_flags", {29'h0, flag_c, flag_z, flag_n}, 32'd0);
    @(negedge clk);
    check("rst_mid_no_done", {31'h0, done}, 32'd0);

    // Random loads followed by random instructions.
    for (int i = 1; i < 8; i++)
      run_instr(enc(6'h10, 3'(i), 3'd0, 3'd0, 1'b1, 16'($urandom)));
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [5:0] op;
      k  = $urandom_range(0, 11);
      op = (k < 10) ? legal_ops[k] : bad_ops[$urandom_range(0, 3)];
      run_instr(enc(op, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 16'($urandom)));
    end

    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("final_regs", dbg_data, m_reg[i]);
    end

`ifdef ALU_CU_PERF_CNT_EN
    check("retired_cnt", retired_cnt, 32'(cnt_done));
    check("illegal_cnt", illegal_cnt, 32'(cnt_ill));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
